storage_arbiter: RTL and testbench

- Sequenced, registered arbiter that shares the single-port matrix storage between three requesters: input subsystem (index 0), display subsystem (index 1) and calculator core (index 2).
- Replaces the purely enable-driven storage mux with an explicit req/gnt handshake, round-robin fairness and a burst limit.
- Routes synchronous-read data back to the requester that issued the read, using a per-requester rvalid strobe.
- Sits between the three requesters and the storage array, under the main FSM.

---
 rtl/storage_arbiter.sv | 159 +++++++++++++++
 tb/tb_storage_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/storage_arbiter.sv
// Round-robin req/gnt arbiter sharing the single-port matrix storage between three requesters.
// Define ARB_STATS_EN to add the saturating contention counter on o_conflict_cnt.
module storage_arbiter #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          i_req,
   input  logic [3*ADDR_W-1:0] i_addr,
   input  logic [2:0]          i_we,
   input  logic [3*DATA_W-1:0] i_wdata,
   output logic [2:0]          o_gnt,
   output logic [2:0]          o_rvalid,
   output logic [DATA_W-1:0]   o_rdata,
   output logic [ADDR_W-1:0]   o_storage_addr,
   output logic [DATA_W-1:0]   o_storage_data,
   output logic                o_storage_we,
   input  logic [DATA_W-1:0]   i_storage_rdata,
`ifdef ARB_STATS_EN
   output logic [15:0]         o_conflict_cnt,
`endif
   output logic                o_busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;
   localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

   logic [0:0]        state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        last_q, last_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              rd_valid_q;
   logic [1:0]        rd_tag_q;

   logic [1:0]        cand_a, cand_b, winner;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_data;
   logic              own_req, own_we, others_req, in_own, beat;
   logic [7:0]        cnt_inc;

   function automatic logic [1:0] next_idx(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] v);
      return 3'b001 << v;
   endfunction

   // Search order after the last owner: last+1, last+2, then last itself.
   always_comb begin
      cand_a = next_idx(last_q);
      cand_b = next_idx(cand_a);
      if (i_req[cand_a])      winner = cand_a;
      else if (i_req[cand_b]) winner = cand_b;
      else                    winner = last_q;
   end

   always_comb begin
      own_addr = i_addr[ADDR_W-1:0];
      own_data = i_wdata[DATA_W-1:0];
      case (owner_q)
         2'd1: begin
            own_addr = i_addr[2*ADDR_W-1:ADDR_W];
            own_data = i_wdata[2*DATA_W-1:DATA_W];
         end
         2'd2: begin
            own_addr = i_addr[3*ADDR_W-1:2*ADDR_W];
            own_data = i_wdata[3*DATA_W-1:2*DATA_W];
         end
         default: ;
      endcase
   end

   assign own_req    = i_req[owner_q];
   assign own_we     = i_we[owner_q];
   assign others_req = |(i_req & ~onehot(owner_q));
   assign in_own     = (state_q == ST_OWN);
   assign beat       = in_own & own_req;
   assign cnt_inc    = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req) begin
               state_d = ST_OWN;
               owner_d = winner;
               cnt_d   = 8'd0;
            end
         end
         default: begin
            if (!own_req) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
               cnt_d   = 8'd0;
            end else if ((cnt_inc == MAX_CNT) && others_req) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= 2'd2;
         last_q     <= 2'd2;
         cnt_q      <= 8'd0;
         rd_valid_q <= 1'b0;
         rd_tag_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         // Tag is kept outside the FSM so the final read of a released burst still returns.
         rd_valid_q <= beat & ~own_we;
         rd_tag_q   <= owner_q;
      end
   end

   assign o_gnt          = in_own ? onehot(owner_q) : 3'b000;
   assign o_busy         = in_own;
   assign o_storage_addr = own_addr;
   assign o_storage_data = own_data;
   assign o_storage_we   = beat & own_we & ~rst;
   assign o_rvalid       = rd_valid_q ? onehot(rd_tag_q) : 3'b000;
   assign o_rdata        = i_storage_rdata;

`ifdef ARB_STATS_EN
   logic [1:0]  req_pop;
   logic        conflict;
   logic [15:0] conflict_q;

   assign req_pop  = 2'(i_req[0]) + 2'(i_req[1]) + 2'(i_req[2]);
   assign conflict = (req_pop >= 2'd2) && (|(i_req & ~o_gnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_q <= 16'd0;
      end else if (conflict && (conflict_q != 16'hFFFF)) begin
         conflict_q <= conflict_q + 16'd1;
      end
   end

   assign o_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed self-checking bench for storage_arbiter (MAX_BURST=4); storage modelled as a
// registered-read memory. Stats checks compile in when ARB_STATS_EN is defined.
module tb_storage_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [23:0] addr = '0;
   logic [2:0]  we = '0;
   logic [95:0] wdata = '0;
   logic [2:0]  gnt, rvalid;
   logic [31:0] rdata, sdata, srdata;
   logic [7:0]  saddr;
   logic        swe, busy;
`ifdef ARB_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   logic [2:0]  req_tab [16];
   logic [2:0]  gnt_tab [16];

   storage_arbiter #(
      .ADDR_W(8), .DATA_W(32), .MAX_BURST(4)
   ) dut (
      .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_we(we), .i_wdata(wdata),
      .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_storage_addr(saddr),
      .o_storage_data(sdata), .o_storage_we(swe), .i_storage_rdata(srdata),
`ifdef ARB_STATS_EN
      .o_conflict_cnt(conflict_cnt),
`endif
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      mem[5] <= 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      if (swe) mem[saddr] <= sdata;
      srdata <= mem[saddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked at the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_dut();
      rst = 1'b1;
      req = '0;
      we  = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      req_tab = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110,
                  3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
      gnt_tab = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                  3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};

      // Reset state and single read from input subsystem.
      rst_dut();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(swe), 0);
      step(); req = 3'b001; addr[7:0] = 8'h05; @(negedge clk);
      chk("rd_gnt_lat0", 32'(gnt), 0);
      step(); @(negedge clk);
      chk("rd_gnt", 32'(gnt), 32'b001);
      chk("rd_busy", 32'(busy), 1);
      chk("rd_saddr", 32'(saddr), 32'h05);
      chk("rd_swe", 32'(swe), 0);
      chk("rd_rvalid_early", 32'(rvalid), 0);
      step(); req = 3'b000; @(negedge clk);
      chk("rd_rvalid", 32'(rvalid), 32'b001);
      chk("rd_rdata", rdata, 32'hDEAD_BEEF);
      step(); @(negedge clk);
      chk("rd_gnt_off", 32'(gnt), 0);
      chk("rd_rvalid_off", 32'(rvalid), 0);
      chk("rd_busy_off", 32'(busy), 0);

      // Calculator writes 7 to 0x20, then reads it back.
      rst_dut();
      step(); req = 3'b100; we = 3'b100; addr[23:16] = 8'h20; wdata[95:64] = 32'h7;
      @(negedge clk);
      chk("wr_idle_we", 32'(swe), 0);
      step(); @(negedge clk);
      chk("wr_gnt", 32'(gnt), 32'b100);
      chk("wr_we", 32'(swe), 1);
      chk("wr_saddr", 32'(saddr), 32'h20);
      chk("wr_sdata", sdata, 32'h7);
      step(); we = 3'b000; @(negedge clk);
      chk("wr_rd_we", 32'(swe), 0);
      chk("wr_rd_rvalid0", 32'(rvalid), 0);
      step(); req = 3'b000; @(negedge clk);
      chk("wr_rb_rvalid", 32'(rvalid), 32'b100);
      chk("wr_rb_rdata", rdata, 32'h7);
      step(); @(negedge clk);
      chk("wr_end_gnt", 32'(gnt), 0);

      // Three-way contention: each owner takes 3 beats, then drops req.
      rst_dut();
      for (int t = 0; t < 16; t++) begin
         step(); req = req_tab[t]; @(negedge clk);
         chk($sformatf("rr_gnt_c%0d", t), 32'(gnt), 32'(gnt_tab[t]));
      end

      // Burst limit: calc streams 10 reads, display cuts in after 4 beats.
      rst_dut();
      step(); req = 3'b100; addr[23:16] = 8'h10; @(negedge clk);
      chk("bl_gnt0", 32'(gnt), 0);
      for (int k = 0; k < 4; k++) begin
         step(); addr[23:16] = 8'(8'h10 + k);
         if (k == 0) begin req = 3'b110; addr[15:8] = 8'h40; end
         @(negedge clk);
         chk($sformatf("bl_gnt_k%0d", k), 32'(gnt), 32'b100);
         chk($sformatf("bl_saddr_k%0d", k), 32'(saddr), 32'h10 + k);
         if (k > 0) begin
            chk($sformatf("bl_rv_k%0d", k), 32'(rvalid), 32'b100);
            chk($sformatf("bl_rd_k%0d", k), rdata, 32'hA000_0010 + k - 1);
         end
      end
      step(); addr[23:16] = 8'h14; @(negedge clk);
      chk("bl_bubble_gnt", 32'(gnt), 0);
      chk("bl_4th_rv", 32'(rvalid), 32'b100);
      chk("bl_4th_rd", rdata, 32'hA000_0013);
      step(); @(negedge clk);
      chk("bl_disp_gnt", 32'(gnt), 32'b010);
      chk("bl_disp_saddr", 32'(saddr), 32'h40);
      step(); req = 3'b100; @(negedge clk);
      chk("bl_disp_rv", 32'(rvalid), 32'b010);
      chk("bl_disp_rd", rdata, 32'hA000_0040);
      step(); @(negedge clk);
      chk("bl_bubble2_gnt", 32'(gnt), 0);
      for (int k = 4; k < 10; k++) begin
         step(); addr[23:16] = 8'(8'h10 + k); @(negedge clk);
         chk($sformatf("bl2_gnt_k%0d", k), 32'(gnt), 32'b100);
         chk($sformatf("bl2_rv_k%0d", k), 32'(rvalid), (k > 4) ? 32'b100 : 32'b000);
         if (k > 4) chk($sformatf("bl2_rd_k%0d", k), rdata, 32'hA000_0010 + k - 1);
      end
      step(); req = 3'b000; @(negedge clk);
      chk("bl_last_rv", 32'(rvalid), 32'b100);
      chk("bl_last_rd", rdata, 32'hA000_0019);

      // Display streams 40 reads alone: no forced release.
      rst_dut();
      step(); req = 3'b010; addr[15:8] = 8'h80; @(negedge clk);
      chk("st_gnt0", 32'(gnt), 0);
      for (int k = 0; k < 40; k++) begin
         step(); addr[15:8] = 8'(8'h80 + k); @(negedge clk);
         chk($sformatf("st_gnt_k%0d", k), 32'(gnt), 32'b010);
         chk($sformatf("st_rv_k%0d", k), 32'(rvalid), (k > 0) ? 32'b010 : 32'b000);
         if (k > 0) chk($sformatf("st_rd_k%0d", k), rdata, 32'hA000_0080 + k - 1);
      end
      step(); req = 3'b000; @(negedge clk);
      chk("st_last_rv", 32'(rvalid), 32'b010);
      chk("st_last_rd", rdata, 32'hA000_00A7);

      // Reset while calc owns the storage and is writing.
      rst_dut();
      step(); req = 3'b100; we = 3'b000; addr[23:16] = 8'h30; wdata[95:64] = 32'h55;
      @(negedge clk);
      step(); @(negedge clk);
      chk("mr_gnt", 32'(gnt), 32'b100);
      step(); rst = 1'b1; we = 3'b100; @(negedge clk);
      chk("mr_rst_we", 32'(swe), 0);
      chk("mr_rst_rv", 32'(rvalid), 32'b100);
      step(); rst = 1'b0; @(negedge clk);
      chk("mr_gnt_after", 32'(gnt), 0);
      chk("mr_rv_after", 32'(rvalid), 0);
      chk("mr_we_after", 32'(swe), 0);
      chk("mr_busy_after", 32'(busy), 0);
`ifdef ARB_STATS_EN
      chk("cc_after_rst", 32'(conflict_cnt), 0);

      // Two-way overlap held for 3 cycles.
      rst_dut();
      step(); req = 3'b011; we = 3'b000; @(negedge clk);
      chk("cc_zero", 32'(conflict_cnt), 0);
      step(); @(negedge clk);
      step(); @(negedge clk);
      step(); req = 3'b001; @(negedge clk);
      chk("cc_three", 32'(conflict_cnt), 3);
      step(); @(negedge clk);
      chk("cc_hold", 32'(conflict_cnt), 3);
`endif
      step(); req = 3'b000;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
